mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and feeds write-back. It consumes the EX/MEM pipeline register contents and drives the CPU-to-cache request/ready handshake. It formats store data and byte strobes, sign- or zero-extends load data, and raises `stall_o` while a cache access is outstanding. It owns the MEM/WB pipeline register, with the same `enable_i`/`reset_i` (hold/flush) semantics as the other stages.

## Interface
- No parameters; XLEN fixed at 32.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: MEM/WB register update enable (0 = hold).
- `reset_i` in 1: synchronous flush of MEM/WB; effective only when `enable_i`=1.
- `alu_mem_i` in 32: effective address or ALU result.
- `rs2_mem_i` in 32: store data.
- `pc4_mem_i` in 32: pc+4.
- `inst_mem_i` in 32: instruction; funct3 = `[14:12]`.
- `MemRW_mem_i` in 1: 1 = store, 0 = load.
- `WBSel_mem_i` in 2: write-back select.
- `RegWEn_mem_i` in 1: register write enable.
- `rsW_mem_i` in 5: destination register.
- `Valid_cpu2cache_mem_i` in 1: instruction accesses memory.
- `csr_we_mem_i` in 1, `csr_waddr_mem_i` in 32, `csr_rdata_mem_i` in 32: CSR sideband, passed through.
- `cache_valid_o` out 1: request valid.
- `cache_rw_o` out 1: 1 = write.
- `cache_addr_o` out 32: word-aligned address `{alu[31:2],2'b00}`.
- `cache_wdata_o` out 32: replicated store data.
- `cache_wstrb_o` out 4: byte strobes.
- `cache_ready_i` in 1: request completes this cycle.
- `cache_rdata_i` in 32: read word, valid when `cache_ready_i`=1.
- `stall_o` out 1: hold the whole pipeline.
- `misalign_o` out 1: misaligned access flagged this cycle.
- `alu_wb_o`, `mem_wb_o`, `pc4_wb_o`, `inst_wb_o` out 32 each; `WBSel_wb_o` out 2; `RegWEn_wb_o` out 1; `rsW_wb_o` out 5; `csr_we_wb_o` out 1; `csr_waddr_wb_o` out 32; `csr_rdata_wb_o` out 32: MEM/WB register outputs.

## Operation
- **Access qualification**
  - acc = `Valid_cpu2cache_mem_i` & !misaligned.
  - misaligned = (halfword & `alu[0]`) | (word & `alu[1:0]`≠0).
  - `misalign_o` = `Valid_cpu2cache_mem_i` & misaligned (combinational).
  - A misaligned access issues no request, and its `RegWEn_wb_o` is forced to 0.
- **Store formatting**
  - SB (funct3 000): wstrb = 4'b0001<<`alu[1:0]`, wdata = {4{rs2[7:0]}}.
  - SH (001): wstrb = 4'b0011<<{`alu[1]`,1'b0}, wdata = {2{rs2[15:0]}}.
  - SW (010): wstrb = 4'b1111, wdata = rs2.
  - Loads: wstrb = 4'b0000.
- **Load extraction**
  - Shift `cache_rdata_i` right by 8·`alu[1:0]`.
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) passes the full word.
- **FSM states**
  - IDLE:
    - `cache_valid_o` = acc.
    - If acc & ready: complete; if `enable_i`, load MEM/WB and stay in IDLE, else capture the formatted data into the hold register and go to DONE.
    - If acc & !ready: go to WAIT.
  - WAIT:
    - `cache_valid_o`=1; address, data, strobes and rw held stable from the EX/MEM inputs, which are frozen by the stall.
    - On ready: same completion rule as IDLE.
  - DONE:
    - `cache_valid_o`=0, so no re-issue while the pipeline is held by another hazard.
    - MEM/WB uses the hold register; on `enable_i`, return to IDLE.
- `stall_o` = acc & !`cache_ready_i` & (IDLE | WAIT).
- **Flush vs. stall**
  - A flush (`reset_i`) never aborts an issued request.
  - In WAIT, the FSM completes the handshake; the result is discarded only when the flush is applied with `enable_i`=1.
- **Non-memory instructions**: MEM/WB is loaded directly from the inputs and `mem_wb_o` is 0.

## Timing
- On `rst_ni` low: FSM goes to IDLE, and the hold register and all MEM/WB outputs go to 0.
  - `cache_valid_o`, `stall_o` and `misalign_o` are combinational and read 0 during reset.
- Hit with a combinational same-cycle ready: zero stall; MEM/WB updates at that clock edge.
- N-cycle miss: `stall_o` is high for N cycles; MEM/WB updates at the edge where `cache_ready_i`=1.
- `cache_valid_o` stays high with stable address/data/strobe/rw until ready is seen; a request is never retracted.
- Simultaneous `reset_i` & `enable_i` in WAIT with ready: the handshake completes, MEM/WB is zeroed, and the FSM goes to IDLE.
- The 32-bit address never wraps into a byte lane; a cross-word access is always flagged misaligned.

## Test plan
- LW, addr 0x100, ready same cycle, rdata 0xDEADBEEF -> `mem_wb_o`=0xDEADBEEF next edge, `stall_o` never high.
- LB at 0x103, rdata 0x80FF_FFFF -> `mem_wb_o`=0xFFFFFF80; LBU same -> 0x00000080; LHU at 0x102 -> 0x000080FF.
- SH, addr 0x206, rs2 0x1234ABCD -> `cache_addr_o`=0x204, wstrb 4'b1100, wdata 0xABCDABCD.
- LW with ready delayed 3 cycles -> `stall_o` high exactly 3 cycles, valid/address stable, result captured on the 4th edge.
- Ready arrives while `enable_i`=0 for 2 cycles -> FSM in DONE, valid low, data held, written to MEM/WB when `enable_i` rises.
- SW at 0x302 -> `misalign_o`=1, no `cache_valid_o`, `RegWEn_wb_o`=0; `rst_ni` asserted mid-WAIT -> all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the cache request/ready handshake, formats store
// data and strobes, extends load data and owns the MEM/WB pipeline register.
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        reset_i,
    input  logic [31:0] alu_mem_i,
    input  logic [31:0] rs2_mem_i,
    input  logic [31:0] pc4_mem_i,
    input  logic [31:0] inst_mem_i,
    input  logic        MemRW_mem_i,
    input  logic [1:0]  WBSel_mem_i,
    input  logic        RegWEn_mem_i,
    input  logic [4:0]  rsW_mem_i,
    input  logic        Valid_cpu2cache_mem_i,
    input  logic        csr_we_mem_i,
    input  logic [31:0] csr_waddr_mem_i,
    input  logic [31:0] csr_rdata_mem_i,
    output logic        cache_valid_o,
    output logic        cache_rw_o,
    output logic [31:0] cache_addr_o,
    output logic [31:0] cache_wdata_o,
    output logic [3:0]  cache_wstrb_o,
    input  logic        cache_ready_i,
    input  logic [31:0] cache_rdata_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [31:0] alu_wb_o,
    output logic [31:0] mem_wb_o,
    output logic [31:0] pc4_wb_o,
    output logic [31:0] inst_wb_o,
    output logic [1:0]  WBSel_wb_o,
    output logic        RegWEn_wb_o,
    output logic [4:0]  rsW_wb_o,
    output logic        csr_we_wb_o,
    output logic [31:0] csr_waddr_wb_o,
    output logic [31:0] csr_rdata_wb_o
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StWait = 2'b01;
    localparam logic [1:0] StDone = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] hold_q, hold_d;

    logic [31:0] alu_wb_q, alu_wb_d, mem_wb_q, mem_wb_d, pc4_wb_q, pc4_wb_d;
    logic [31:0] inst_wb_q, inst_wb_d, csr_waddr_wb_q, csr_waddr_wb_d;
    logic [31:0] csr_rdata_wb_q, csr_rdata_wb_d;
    logic [1:0]  wbsel_wb_q, wbsel_wb_d;
    logic        regwen_wb_q, regwen_wb_d, csr_we_wb_q, csr_we_wb_d;
    logic [4:0]  rsw_wb_q, rsw_wb_d;

    logic [2:0]  funct3;
    logic        misaligned, acc, complete, stall, req_valid;
    logic [31:0] rdata_shift, load_ext, fmt_data;

    assign funct3 = inst_mem_i[14:12];

    // Halfword needs bit 0 clear, word needs both low bits clear; so no access crosses a word.
    assign misaligned = ((funct3[1:0] == 2'b01) & alu_mem_i[0])
                      | ((funct3[1:0] == 2'b10) & (alu_mem_i[1:0] != 2'b00));
    assign acc        = Valid_cpu2cache_mem_i & ~misaligned;

    assign complete = cache_ready_i & (((state_q == StIdle) & acc) | (state_q == StWait));
    assign stall    = acc & ~cache_ready_i & (state_q != StDone);

    // Request is live while issuing from IDLE and held until ready in WAIT; never in DONE.
    always_comb begin
        req_valid = 1'b0;
        case (state_q)
            StIdle:  req_valid = acc;
            StWait:  req_valid = 1'b1;
            default: req_valid = 1'b0;
        endcase
    end

    // Combinational handshake outputs are forced low while reset is asserted.
    assign cache_valid_o = rst_ni & req_valid;
    assign stall_o       = rst_ni & stall;
    assign misalign_o    = rst_ni & Valid_cpu2cache_mem_i & misaligned;
    assign cache_rw_o    = MemRW_mem_i;
    assign cache_addr_o  = {alu_mem_i[31:2], 2'b00};

    // Store formatting: replicate data across lanes and enable only the addressed bytes.
    always_comb begin
        cache_wstrb_o = 4'b0000;
        cache_wdata_o = 32'h0;
        if (MemRW_mem_i) begin
            case (funct3[1:0])
                2'b00: begin
                    cache_wstrb_o = 4'b0001 << alu_mem_i[1:0];
                    cache_wdata_o = {4{rs2_mem_i[7:0]}};
                end
                2'b01: begin
                    cache_wstrb_o = 4'b0011 << {alu_mem_i[1], 1'b0};
                    cache_wdata_o = {2{rs2_mem_i[15:0]}};
                end
                2'b10: begin
                    cache_wstrb_o = 4'b1111;
                    cache_wdata_o = rs2_mem_i;
                end
                default: begin
                    cache_wstrb_o = 4'b0000;
                    cache_wdata_o = 32'h0;
                end
            endcase
        end
    end

    assign rdata_shift = cache_rdata_i >> {alu_mem_i[1:0], 3'b000};

    // Load extraction: align the addressed lane to bit 0, then sign- or zero-extend.
    always_comb begin
        load_ext = rdata_shift;
        case (funct3)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_ext = {24'h0, rdata_shift[7:0]};
            3'b101:  load_ext = {16'h0, rdata_shift[15:0]};
            default: load_ext = cache_rdata_i;
        endcase
    end

    // Only aligned loads produce memory data; stores and non-memory ops write back 0.
    assign fmt_data = (acc & ~MemRW_mem_i) ? load_ext : 32'h0;

    // Access FSM and hold register for results that complete while the pipeline is held.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: if (acc) state_d = cache_ready_i ? (enable_i ? StIdle : StDone) : StWait;
            StWait: if (cache_ready_i) state_d = enable_i ? StIdle : StDone;
            StDone: if (enable_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (complete && !enable_i) hold_d = fmt_data;
    end

    // MEM/WB next state: flush wins when enabled, otherwise load unless a miss is stalling.
    always_comb begin
        alu_wb_d       = alu_wb_q;
        mem_wb_d       = mem_wb_q;
        pc4_wb_d       = pc4_wb_q;
        inst_wb_d      = inst_wb_q;
        wbsel_wb_d     = wbsel_wb_q;
        regwen_wb_d    = regwen_wb_q;
        rsw_wb_d       = rsw_wb_q;
        csr_we_wb_d    = csr_we_wb_q;
        csr_waddr_wb_d = csr_waddr_wb_q;
        csr_rdata_wb_d = csr_rdata_wb_q;
        if (enable_i && reset_i) begin
            alu_wb_d       = 32'h0;
            mem_wb_d       = 32'h0;
            pc4_wb_d       = 32'h0;
            inst_wb_d      = 32'h0;
            wbsel_wb_d     = 2'b00;
            regwen_wb_d    = 1'b0;
            rsw_wb_d       = 5'd0;
            csr_we_wb_d    = 1'b0;
            csr_waddr_wb_d = 32'h0;
            csr_rdata_wb_d = 32'h0;
        end else if (enable_i && !stall) begin
            alu_wb_d       = alu_mem_i;
            mem_wb_d       = (state_q == StDone) ? hold_q : fmt_data;
            pc4_wb_d       = pc4_mem_i;
            inst_wb_d      = inst_mem_i;
            wbsel_wb_d     = WBSel_mem_i;
            regwen_wb_d    = RegWEn_mem_i & ~(Valid_cpu2cache_mem_i & misaligned);
            rsw_wb_d       = rsW_mem_i;
            csr_we_wb_d    = csr_we_mem_i;
            csr_waddr_wb_d = csr_waddr_mem_i;
            csr_rdata_wb_d = csr_rdata_mem_i;
        end
    end

    // State, hold and MEM/WB registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            hold_q         <= 32'h0;
            alu_wb_q       <= 32'h0;
            mem_wb_q       <= 32'h0;
            pc4_wb_q       <= 32'h0;
            inst_wb_q      <= 32'h0;
            wbsel_wb_q     <= 2'b00;
            regwen_wb_q    <= 1'b0;
            rsw_wb_q       <= 5'd0;
            csr_we_wb_q    <= 1'b0;
            csr_waddr_wb_q <= 32'h0;
            csr_rdata_wb_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            alu_wb_q       <= alu_wb_d;
            mem_wb_q       <= mem_wb_d;
            pc4_wb_q       <= pc4_wb_d;
            inst_wb_q      <= inst_wb_d;
            wbsel_wb_q     <= wbsel_wb_d;
            regwen_wb_q    <= regwen_wb_d;
            rsw_wb_q       <= rsw_wb_d;
            csr_we_wb_q    <= csr_we_wb_d;
            csr_waddr_wb_q <= csr_waddr_wb_d;
            csr_rdata_wb_q <= csr_rdata_wb_d;
        end
    end

    assign alu_wb_o       = alu_wb_q;
    assign mem_wb_o       = mem_wb_q;
    assign pc4_wb_o       = pc4_wb_q;
    assign inst_wb_o      = inst_wb_q;
    assign WBSel_wb_o     = wbsel_wb_q;
    assign RegWEn_wb_o    = regwen_wb_q;
    assign rsW_wb_o       = rsw_wb_q;
    assign csr_we_wb_o    = csr_we_wb_q;
    assign csr_waddr_wb_o = csr_waddr_wb_q;
    assign csr_rdata_wb_o = csr_rdata_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB results are queued when an access is
// driven and compared when the stage completes it.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, flush;
    logic [31:0] alu, rs2, pc4, inst;
    logic        memrw, regwen, valid, csr_we;
    logic [1:0]  wbsel;
    logic [4:0]  rsw;
    logic [31:0] csr_waddr, csr_rdata;
    logic        c_valid, c_rw, c_ready, stall, misalign;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_wstrb;
    logic [31:0] alu_wb, mem_wb, pc4_wb, inst_wb, csr_waddr_wb, csr_rdata_wb;
    logic [1:0]  wbsel_wb;
    logic        regwen_wb, csr_we_wb;
    logic [4:0]  rsw_wb;

    typedef struct packed {
        logic [31:0] mem;
        logic        rwe;
        logic [31:0] alu;
    } exp_t;
    exp_t sb_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_mem = 32'h0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .reset_i(flush),
        .alu_mem_i(alu), .rs2_mem_i(rs2), .pc4_mem_i(pc4), .inst_mem_i(inst),
        .MemRW_mem_i(memrw), .WBSel_mem_i(wbsel), .RegWEn_mem_i(regwen), .rsW_mem_i(rsw),
        .Valid_cpu2cache_mem_i(valid), .csr_we_mem_i(csr_we),
        .csr_waddr_mem_i(csr_waddr), .csr_rdata_mem_i(csr_rdata),
        .cache_valid_o(c_valid), .cache_rw_o(c_rw), .cache_addr_o(c_addr),
        .cache_wdata_o(c_wdata), .cache_wstrb_o(c_wstrb), .cache_ready_i(c_ready),
        .cache_rdata_i(c_rdata), .stall_o(stall), .misalign_o(misalign),
        .alu_wb_o(alu_wb), .mem_wb_o(mem_wb), .pc4_wb_o(pc4_wb), .inst_wb_o(inst_wb),
        .WBSel_wb_o(wbsel_wb), .RegWEn_wb_o(regwen_wb), .rsW_wb_o(rsw_wb),
        .csr_we_wb_o(csr_we_wb), .csr_waddr_wb_o(csr_waddr_wb), .csr_rdata_wb_o(csr_rdata_wb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference load extraction, written lane-by-lane.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a[1:0] +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    task automatic drive(input logic [2:0] f3, input logic rw, input logic [31:0] a,
                         input logic [31:0] d, input logic v);
        inst   = {17'h0, f3, 12'h003};
        memrw  = rw;
        alu    = a;
        rs2    = d;
        valid  = v;
        regwen = ~rw;
        pc4    = a + 32'd4;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h, expected an entry", tag, mem_wb);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_mem"}, mem_wb, e.mem);
            check_eq({tag, "_rwe"}, {31'h0, regwen_wb}, {31'h0, e.rwe});
            check_eq({tag, "_alu"}, alu_wb, e.alu);
            last_mem = e.mem;
        end
    endtask

    // Completes the currently driven access after `dly` not-ready cycles.
    task automatic run_access(input string tag, input int dly, input logic [31:0] rd);
        int stalls = 0;
        c_ready = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            stalls += int'(stall);
            check_eq({tag, "_vld"}, {31'h0, c_valid}, 32'h1);
            check_eq({tag, "_adr"}, c_addr, {alu[31:2], 2'b00});
            check_eq({tag, "_hold"}, mem_wb, last_mem);
            @(posedge clk); #1;
        end
        c_ready = 1'b1;
        c_rdata = rd;
        @(negedge clk);
        stalls += int'(stall);
        @(posedge clk); #1;
        c_ready = 1'b0;
        check_eq({tag, "_stalls"}, stalls, dly);
        pop_check(tag);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0; c_ready = 1'b0; c_rdata = 32'h0;
        wbsel = 2'b01; rsw = 5'd7; csr_we = 1'b0; csr_waddr = 32'h0; csr_rdata = 32'h0;
        drive(3'd2, 1'b0, 32'h100, 32'h0, 1'b1);
        #3;
        check_eq("rst_vld", {31'h0, c_valid}, 32'h0);
        check_eq("rst_mem", mem_wb, 32'h0);
        check_eq("rst_alu", alu_wb, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // The IDLE issue at the first edge may have gone out; restart cleanly.
        rst_n = 1'b0; #1; rst_n = 1'b1;

        // Hits with same-cycle ready
        drive(3'd2, 1'b0, 32'h100, 32'h0, 1'b1);
        sb_q.push_back('{exp_load(3'd2, 32'h100, 32'hDEADBEEF), 1'b1, 32'h100});
        run_access("lw_hit", 0, 32'hDEADBEEF);
        drive(3'd0, 1'b0, 32'h103, 32'h0, 1'b1);
        sb_q.push_back('{32'hFFFFFF80, 1'b1, 32'h103});
        run_access("lb", 0, 32'h80FFFFFF);
        drive(3'd4, 1'b0, 32'h103, 32'h0, 1'b1);
        sb_q.push_back('{32'h00000080, 1'b1, 32'h103});
        run_access("lbu", 0, 32'h80FFFFFF);
        drive(3'd5, 1'b0, 32'h102, 32'h0, 1'b1);
        sb_q.push_back('{exp_load(3'd5, 32'h102, 32'h80FFFFFF), 1'b1, 32'h102});
        run_access("lhu", 0, 32'h80FFFFFF);
        drive(3'd1, 1'b0, 32'h0FE, 32'h0, 1'b1);
        sb_q.push_back('{exp_load(3'd1, 32'h0FE, 32'h9ABC1234), 1'b1, 32'h0FE});
        run_access("lh", 0, 32'h9ABC1234);

        // Store formatting
        drive(3'd1, 1'b1, 32'h206, 32'h1234ABCD, 1'b1);
        #1;
        check_eq("sh_adr", c_addr, 32'h204);
        check_eq("sh_strb", {28'h0, c_wstrb}, 32'hC);
        check_eq("sh_wdat", c_wdata, 32'hABCDABCD);
        check_eq("sh_rw", {31'h0, c_rw}, 32'h1);
        sb_q.push_back('{32'h0, 1'b0, 32'h206});
        run_access("sh", 0, 32'h55555555);
        drive(3'd0, 1'b1, 32'h101, 32'h000000AB, 1'b1);
        #1;
        check_eq("sb_strb", {28'h0, c_wstrb}, 32'h2);
        check_eq("sb_wdat", c_wdata, 32'hABABABAB);
        sb_q.push_back('{32'h0, 1'b0, 32'h101});
        run_access("sb", 0, 32'h0);

        // 3-cycle miss
        drive(3'd2, 1'b0, 32'h180, 32'h0, 1'b1);
        sb_q.push_back('{32'hCAFEF00D, 1'b1, 32'h180});
        run_access("lw_miss", 3, 32'hCAFEF00D);

        // Ready while the pipeline is held: result parks in DONE
        drive(3'd2, 1'b0, 32'h400, 32'h0, 1'b1);
        enable = 1'b0;
        c_ready = 1'b1; c_rdata = 32'h11223344;
        sb_q.push_back('{32'h11223344, 1'b1, 32'h400});
        @(negedge clk);
        check_eq("done_stall0", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        c_ready = 1'b0; c_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("done_vld", {31'h0, c_valid}, 32'h0);
            check_eq("done_stall", {31'h0, stall}, 32'h0);
            check_eq("done_hold", mem_wb, last_mem);
            if (i == 0) begin @(posedge clk); #1; end
        end
        enable = 1'b1;
        @(posedge clk); #1;
        pop_check("done");
        valid = 1'b0;

        // Non-memory instruction
        drive(3'd2, 1'b0, 32'h55, 32'h0, 1'b0);
        sb_q.push_back('{32'h0, 1'b1, 32'h55});
        @(posedge clk); #1;
        pop_check("alu_op");

        // Misaligned word store
        drive(3'd2, 1'b1, 32'h302, 32'h0, 1'b1);
        regwen = 1'b1;
        sb_q.push_back('{32'h0, 1'b0, 32'h302});
        @(negedge clk);
        check_eq("mis_flag", {31'h0, misalign}, 32'h1);
        check_eq("mis_vld", {31'h0, c_valid}, 32'h0);
        check_eq("mis_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        pop_check("mis");

        // Flush with enable while WAIT sees ready: handshake completes, MEM/WB zeroed
        drive(3'd2, 1'b0, 32'h600, 32'h0, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1; c_ready = 1'b1; c_rdata = 32'h12345678;
        sb_q.push_back('{32'h0, 1'b0, 32'h0});
        @(posedge clk); #1;
        flush = 1'b0; c_ready = 1'b0; valid = 1'b0;
        pop_check("flush");
        @(negedge clk);
        check_eq("flush_idle", {31'h0, c_valid}, 32'h0);

        // Asynchronous reset in the middle of WAIT
        @(posedge clk); #1;
        drive(3'd2, 1'b0, 32'h500, 32'h0, 1'b1);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstw_vld", {31'h0, c_valid}, 32'h0);
        check_eq("rstw_stall", {31'h0, stall}, 32'h0);
        check_eq("rstw_mem", mem_wb, 32'h0);
        check_eq("rstw_alu", alu_wb, 32'h0);
        check_eq("rstw_pc4", pc4_wb, 32'h0);
        valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        check_eq("rstw_idle", {31'h0, c_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
